// File: rtl/tl_pkg.sv
// Shared light codes, phase encodings and elaboration-time helpers for the N-way
// traffic light controller.
package tl_pkg;

    typedef enum logic [1:0] {
        LT_GREEN  = 2'b00,
        LT_YELLOW = 2'b01,
        LT_RED    = 2'b10
    } light_e;

    typedef enum logic [1:0] {
        PH_GREEN   = 2'b00,
        PH_YELLOW  = 2'b01,
        PH_ALL_RED = 2'b10
    } phase_e;

    function automatic int tl_clog2(input int value);
        int width;
        width = 32'sd0;
        for (int w = 0; w < 31; w++) begin
            width = ((32'sd1 <<< w) < value) ? (w + 32'sd1) : width;
        end
        return width;
    endfunction

    function automatic int tl_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tl_rr_arb.sv
// Combinational round-robin picker: first requesting approach after cur_dir
// (wrapping), or cur_dir+1 when nobody else is requesting.
module tl_rr_arb
    import tl_pkg::*;
#(
    parameter int N_DIR = 4,
    parameter int DW    = 2
) (
    input  logic [N_DIR-1:0] req,
    input  logic [DW-1:0]    cur_dir,
    output logic [DW-1:0]    next_dir
);

    function automatic logic [DW-1:0] wrap_add(input logic [DW-1:0] cur, input int k);
        return DW'((int'(cur) + k) % N_DIR);
    endfunction

    // Scan farthest-first so the nearest requester after cur_dir overwrites last
    always_comb begin
        next_dir = wrap_add(cur_dir, 32'sd1);
        for (int k = N_DIR - 1; k >= 1; k--) begin
            next_dir = req[wrap_add(cur_dir, k)] ? wrap_add(cur_dir, k) : next_dir;
        end
    end

endmodule

// File: rtl/tl_cntr_nway.sv
// N-way traffic light controller: phase FSM, phase timer and registered lamp decode.
// Optional starvation guard enabled by defining TL_MAX_GREEN_EN.
module tl_cntr_nway
    import tl_pkg::*;
#(
    parameter int N_DIR      = 4,
    parameter int MIN_GREEN  = 4,
    parameter int YELLOW_CYC = 2,
    parameter int ALLRED_CYC = 1,
    parameter int MAX_GREEN  = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [N_DIR-1:0]            T,
    output logic [2*N_DIR-1:0]          L,
    output logic [1:0]                  phase,
    output logic [tl_clog2(N_DIR)-1:0]  cur_dir
);

    localparam int DW   = tl_clog2(N_DIR);
    localparam int TMAX = tl_max(tl_max(MIN_GREEN, YELLOW_CYC), tl_max(ALLRED_CYC, MAX_GREEN));
    localparam int TW   = tl_clog2(TMAX + 32'sd1);

    localparam logic [TW-1:0] GRN_END   = TW'(MIN_GREEN - 32'sd1);
    localparam logic [TW-1:0] YEL_END   = TW'(YELLOW_CYC - 32'sd1);
    localparam logic [TW-1:0] AR_END    = TW'((ALLRED_CYC > 32'sd0) ? (ALLRED_CYC - 32'sd1) : 32'sd0);
    localparam logic [TW-1:0] TIMER_SAT = {TW{1'b1}};
    localparam logic [2*N_DIR-1:0] RST_LIGHTS = {{(N_DIR-1){2'b10}}, 2'b00};
`ifdef TL_MAX_GREEN_EN
    localparam logic [TW-1:0] MAXG_END  = TW'(MAX_GREEN - 32'sd1);
`endif

    phase_e             phase_r, phase_nx_s;
    logic [DW-1:0]      dir_r, dir_nx_s, arb_dir_s;
    logic [TW-1:0]      timer_r, timer_nx_s;
    logic [2*N_DIR-1:0] lights_r, lights_s;
    logic [N_DIR-1:0]   cur_oh_s;
    logic               others_wait_s, cur_req_s, green_exit_s;

    tl_rr_arb #(
        .N_DIR (N_DIR),
        .DW    (DW)
    ) u_arb (
        .req      (T),
        .cur_dir  (dir_r),
        .next_dir (arb_dir_s)
    );

    assign cur_oh_s      = {{(N_DIR-1){1'b0}}, 1'b1} << dir_r;
    assign others_wait_s = |(T & ~cur_oh_s);
    assign cur_req_s     = |(T & cur_oh_s);

    // Green exit decision (min-green handoff, optionally max-green forced handoff)
    always_comb begin
`ifdef TL_MAX_GREEN_EN
        green_exit_s = others_wait_s &&
                       (((timer_r >= GRN_END) && !cur_req_s) || (timer_r >= MAXG_END));
`else
        green_exit_s = others_wait_s && (timer_r >= GRN_END) && !cur_req_s;
`endif
    end

    // Next phase / owning approach; the new owner is picked only when clearance ends
    always_comb begin
        phase_nx_s = phase_r;
        dir_nx_s   = dir_r;
        case (phase_r)
            PH_GREEN: begin
                if (green_exit_s) begin
                    phase_nx_s = PH_YELLOW;
                end else begin
                    phase_nx_s = PH_GREEN;
                end
            end
            PH_YELLOW: begin
                if (timer_r < YEL_END) begin
                    phase_nx_s = PH_YELLOW;
                end else if (ALLRED_CYC == 32'sd0) begin
                    phase_nx_s = PH_GREEN;
                    dir_nx_s   = arb_dir_s;
                end else begin
                    phase_nx_s = PH_ALL_RED;
                end
            end
            PH_ALL_RED: begin
                if (timer_r >= AR_END) begin
                    phase_nx_s = PH_GREEN;
                    dir_nx_s   = arb_dir_s;
                end else begin
                    phase_nx_s = PH_ALL_RED;
                end
            end
            default: begin
                phase_nx_s = PH_GREEN;
                dir_nx_s   = '0;
            end
        endcase
    end

    // Phase timer: restarts on every phase change, saturates otherwise
    always_comb begin
        if (phase_nx_s != phase_r) begin
            timer_nx_s = '0;
        end else if (timer_r != TIMER_SAT) begin
            timer_nx_s = timer_r + TW'(1'b1);
        end else begin
            timer_nx_s = timer_r;
        end
    end

    // Lamp decode from the next state so the lamps register alongside phase/cur_dir
    always_comb begin
        lights_s = '0;
        for (int i = 0; i < N_DIR; i++) begin
            if ((DW'(i) == dir_nx_s) && (phase_nx_s == PH_GREEN)) begin
                lights_s[2*i +: 2] = LT_GREEN;
            end else if ((DW'(i) == dir_nx_s) && (phase_nx_s == PH_YELLOW)) begin
                lights_s[2*i +: 2] = LT_YELLOW;
            end else begin
                lights_s[2*i +: 2] = LT_RED;
            end
        end
    end

    // State, timer and lamp registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_r  <= PH_GREEN;
            dir_r    <= '0;
            timer_r  <= '0;
            lights_r <= RST_LIGHTS;
        end else begin
            phase_r  <= phase_nx_s;
            dir_r    <= dir_nx_s;
            timer_r  <= timer_nx_s;
            lights_r <= lights_s;
        end
    end

    assign L       = lights_r;
    assign phase   = phase_r;
    assign cur_dir = dir_r;

endmodule

// File: tb/tb_tl_cntr_nway.sv
// Directed self-checking bench for tl_cntr_nway at default parameters; the
// max-green scenario is selected when TL_MAX_GREEN_EN is defined.
module tb_tl_cntr_nway;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] T;
    logic [7:0] L;
    logic [1:0] phase;
    logic [1:0] cur_dir;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [7:0] EXP_L  [8] = '{8'hA8, 8'hA8, 8'hA8, 8'hA8, 8'hA9, 8'hA9, 8'hAA, 8'h8A};
    localparam logic [1:0] EXP_PH [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd0};
    localparam logic [1:0] EXP_CD [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2};

    tl_cntr_nway #(
        .N_DIR      (4),
        .MIN_GREEN  (4),
        .YELLOW_CYC (2),
        .ALLRED_CYC (1),
        .MAX_GREEN  (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .T       (T),
        .L       (L),
        .phase   (phase),
        .cur_dir (cur_dir)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        int   lit;
        logic any11;
        @(posedge clk);
        #1;
        lit   = 0;
        any11 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (L[2*i +: 2] === 2'b11) any11 = 1'b1;
            if (L[2*i +: 2] !== 2'b10) lit++;
        end
        check_vec("no_code_11", {31'd0, any11}, 32'd0);
        check_vec("single_lit", {31'd0, (lit <= 1)}, 32'd1);
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset(input int n, input logic [3:0] t);
        reset_n = 1'b0;
        T       = t;
        steps(n);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        T       = 4'b0000;

        // Idle reset state and indefinite hold with no traffic
        do_reset(2, 4'b0000);
        check_vec("rst_L", L, 8'hA8);
        check_vec("rst_phase", phase, 2'd0);
        check_vec("rst_dir", cur_dir, 2'd0);
        for (int k = 0; k < 50; k++) begin
            step();
            check_vec("idle_L", L, 8'hA8);
            check_vec("idle_phase", phase, 2'd0);
        end

        // Basic handoff 0 -> 2 with exact cycle timing
        do_reset(1, 4'b0100);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            check_vec("hand_L", L, EXP_L[k]);
            check_vec("hand_phase", phase, EXP_PH[k]);
            check_vec("hand_dir", cur_dir, EXP_CD[k]);
        end

        // Wrap-around arbitration: from dir3, dir0 wins over dir2
        do_reset(1, 4'b1000);
        steps(7);
        check_vec("wrap_d3_dir", cur_dir, 2'd3);
        check_vec("wrap_d3_L", L, 8'h2A);
        T = 4'b0101;
        steps(6);
        check_vec("wrap_ar_phase", phase, 2'd2);
        check_vec("wrap_ar_L", L, 8'hAA);
        step();
        check_vec("wrap_d0_dir", cur_dir, 2'd0);
        check_vec("wrap_d0_L", L, 8'hA8);
        T = 4'b0100;
        steps(7);
        check_vec("wrap_d2_dir", cur_dir, 2'd2);
        check_vec("wrap_d2_L", L, 8'h8A);

`ifdef TL_MAX_GREEN_EN
        // Starvation guard: dir0 forced out after exactly 16 green cycles
        do_reset(1, 4'b0101);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) step();
            check_vec("maxg_green", phase, 2'd0);
        end
        step();
        check_vec("maxg_y0", phase, 2'd1);
        step();
        check_vec("maxg_y1", phase, 2'd1);
        step();
        check_vec("maxg_ar", phase, 2'd2);
        step();
        check_vec("maxg_dir", cur_dir, 2'd2);
        check_vec("maxg_L", L, 8'h8A);
`else
        // Occupied current approach keeps green despite other requests
        do_reset(1, 4'b0101);
        for (int k = 0; k < 40; k++) begin
            step();
            check_vec("hold_phase", phase, 2'd0);
            check_vec("hold_dir", cur_dir, 2'd0);
        end
`endif

        // Reset in the middle of yellow aborts it and restarts the timer
        do_reset(1, 4'b0100);
        steps(4);
        check_vec("mid_yellow", phase, 2'd1);
        reset_n = 1'b0;
        step();
        check_vec("mid_rst_phase", phase, 2'd0);
        check_vec("mid_rst_dir", cur_dir, 2'd0);
        check_vec("mid_rst_L", L, 8'hA8);
        reset_n = 1'b1;
        steps(3);
        check_vec("post_rst_green", phase, 2'd0);
        step();
        check_vec("post_rst_yellow", phase, 2'd1);
        steps(3);
        check_vec("post_rst_dir", cur_dir, 2'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
